fft_result_unloader: RTL and testbench

Streams the final FFT results out of the ping-pong sample memories once the last butterfly stage has completed. It reads the banked layout left by the stage-9 write pattern: pair p is stored at address p, with top in sub-bank a for even p and in sub-bank b for odd p. It emits one complex sample per cycle on a valid/ready stream. It sits between the FFT core's memory read ports and the downstream consumer, and it owns those read ports only while the core is idle.

---
 rtl/fft_pkg.sv | 35 +++
 rtl/fft_result_unloader.sv | 141 ++++++++++++++
 tb/tb_fft_result_unloader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions.
//   LOG2N/N/PAIR_W/DATA_W : transform geometry and sample width
//   MEM1A..MEM2B          : bit positions inside the 4-bit memory read-enable bus
//   unl_state_t           : result-unloader FSM states
//   bitrev10()            : 10-bit bit reversal (beat index -> frequency bin)
package fft_pkg;

  localparam int unsigned LOG2N  = 10;
  localparam int unsigned N      = 1 << LOG2N;
  localparam int unsigned PAIR_W = LOG2N - 1;
  localparam int unsigned DATA_W = 32;

  localparam int unsigned MEM1A = 0;
  localparam int unsigned MEM1B = 1;
  localparam int unsigned MEM2A = 2;
  localparam int unsigned MEM2B = 3;

  typedef enum logic [2:0] {
    UNL_IDLE,
    UNL_FILL,
    UNL_WAIT,
    UNL_RUN,
    UNL_DONE
  } unl_state_t;

  function automatic logic [9:0] bitrev10(input logic [9:0] v);
    logic [9:0] r;
    r = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      r[i] = v[9 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_result_unloader.sv
// Streams the final FFT results out of the ping-pong sample memories.
// Pair p sits at address p; its top is in sub-bank a for even p, sub-bank b
// for odd p. One complex sample per cycle leaves on a valid/ready stream,
// tagged with its bit-reversed beat index (frequency bin).
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_start, i_sel_mem1     frame start pulse; result set select (1 = mem1)
//   o_rd_en[3:0]            read enables {mem2b, mem2a, mem1b, mem1a}
//   o_rd_addr               pair address shared by both sub-banks
//   i_rd_data_a/_b          sub-bank read data, one-cycle latency
//   o_valid/i_ready/o_data  output stream
//   o_tag, o_last           frequency bin, final-beat marker
//   o_busy, o_done          frame in progress, end-of-frame pulse
module fft_result_unloader
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LOG2N  = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_sel_mem1,
  output logic [3:0]        o_rd_en,
  output logic [LOG2N-2:0]  o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data_a,
  input  logic [DATA_W-1:0] i_rd_data_b,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [LOG2N-1:0]  o_tag,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done
);

  unl_state_t        state_q, state_d;
  logic              sel_q;
  logic [LOG2N-1:0]  beat_q;
  logic [DATA_W-1:0] pre_top_q, pre_bot_q, hold_q;
  logic              pre_vld_q;
  logic              cap_q, cap_odd_q;

  logic              rd_issue;
  logic [LOG2N-2:0]  rd_addr;
  logic              top_beat, last_beat, accept;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= UNL_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    rd_issue  = 1'b0;
    rd_addr   = '0;
    o_valid   = 1'b0;
    accept    = 1'b0;
    top_beat  = ~beat_q[0];
    last_beat = &beat_q;
    case (state_q)
      UNL_IDLE: if (i_start) state_d = UNL_FILL;
      UNL_FILL: begin
        rd_issue = 1'b1;
        state_d  = UNL_WAIT;
      end
      UNL_WAIT: state_d = UNL_RUN;
      UNL_RUN: begin
        // Top beats come from the prefetch buffer and must wait for it;
        // bottom beats come from hold_q, which is always loaded by then.
        o_valid = top_beat ? pre_vld_q : 1'b1;
        accept  = o_valid & i_ready;
        if (accept) begin
          // Accepting a top frees pre_q, so the next pair can be fetched now.
          if (top_beat && (beat_q[LOG2N-1:1] != '1)) begin
            rd_issue = 1'b1;
            rd_addr  = beat_q[LOG2N-1:1] + 1'b1;
          end
          if (last_beat) state_d = UNL_DONE;
        end
      end
      UNL_DONE: state_d = UNL_IDLE;
      default:  state_d = UNL_IDLE;
    endcase
  end

  always_comb begin
    o_rd_en = '0;
    if (rd_issue) begin
      if (sel_q) begin
        o_rd_en[MEM1A] = 1'b1;
        o_rd_en[MEM1B] = 1'b1;
      end else begin
        o_rd_en[MEM2A] = 1'b1;
        o_rd_en[MEM2B] = 1'b1;
      end
    end
    o_rd_addr = rd_addr;
    o_data    = o_valid ? (top_beat ? pre_top_q : hold_q) : '0;
    o_tag     = o_valid ? bitrev10(beat_q) : '0;
    o_last    = o_valid & last_beat;
    o_busy    = (state_q == UNL_FILL) || (state_q == UNL_WAIT) || (state_q == UNL_RUN);
    o_done    = (state_q == UNL_DONE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sel_q     <= 1'b0;
      beat_q    <= '0;
      pre_top_q <= '0;
      pre_bot_q <= '0;
      hold_q    <= '0;
      pre_vld_q <= 1'b0;
      cap_q     <= 1'b0;
      cap_odd_q <= 1'b0;
    end else begin
      if ((state_q == UNL_IDLE) && i_start) begin
        sel_q  <= i_sel_mem1;
        beat_q <= '0;
      end
      cap_q     <= rd_issue;
      cap_odd_q <= rd_addr[0];
      if (accept) begin
        if (!last_beat) beat_q <= beat_q + 1'b1;
        if (top_beat) begin
          hold_q    <= pre_bot_q;
          pre_vld_q <= 1'b0;
        end
      end
      // Capture never coincides with a top accept: a top needs pre_vld_q,
      // which is only set by this capture.
      if (cap_q) begin
        pre_top_q <= cap_odd_q ? i_rd_data_b : i_rd_data_a;
        pre_bot_q <= cap_odd_q ? i_rd_data_a : i_rd_data_b;
        pre_vld_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_result_unloader.sv
module tb_fft_result_unloader;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_sel_mem1, i_ready;
  logic [3:0]  o_rd_en;
  logic [8:0]  o_rd_addr;
  logic [31:0] i_rd_data_a, i_rd_data_b, o_data;
  logic        o_valid, o_last, o_busy, o_done;
  logic [9:0]  o_tag;

  always #5 clk = ~clk;

  fft_result_unloader #(.DATA_W(32), .LOG2N(10)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_sel_mem1(i_sel_mem1),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .i_rd_data_a(i_rd_data_a), .i_rd_data_b(i_rd_data_b),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_tag(o_tag),
    .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [9:0]  tag;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0, n_err = 0;
  logic [31:0] salt = '0;
  bit          frame_sel, gapless, rmode, start_mark;
  int          cyc = 0, t_start = 0, beats_rcvd = 0, pulses = 0, done_cnt = 0;
  bit          first_valid_seen;
  bit          prev_stall;
  logic [42:0] prev_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory preload: word identifies its bank and address, perturbed per frame.
  function automatic logic [31:0] mem_word(input logic [15:0] code, input logic [8:0] addr);
    return {code, 7'b0, addr} ^ salt;
  endfunction

  always @(posedge clk) begin
    i_rd_data_a <= o_rd_en[0] ? mem_word(16'h001A, o_rd_addr) :
                   o_rd_en[2] ? mem_word(16'h002A, o_rd_addr) : '0;
    i_rd_data_b <= o_rd_en[1] ? mem_word(16'h001B, o_rd_addr) :
                   o_rd_en[3] ? mem_word(16'h002B, o_rd_addr) : '0;
  end

  // Reference: beat k is half (k%2) of pair k/2; the top half of pair p is in
  // bank a when p is even, bank b when odd; the tag is k with bits mirrored.
  task automatic push_frame(input bit sel);
    exp_t e;
    int   p, t, kk;
    bit   use_b;
    for (int k = 0; k < 1024; k++) begin
      p     = k / 2;
      use_b = ((p % 2) == 1) != ((k % 2) == 1);
      e.d   = mem_word(sel ? (use_b ? 16'h001B : 16'h001A)
                           : (use_b ? 16'h002B : 16'h002A), 9'(p));
      t  = 0;
      kk = k;
      for (int i = 0; i < 10; i++) begin
        t  = t * 2 + (kk % 2);
        kk = kk / 2;
      end
      e.tag  = 10'(t);
      e.last = (k == 1023);
      exp_q.push_back(e);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (i_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (i_start && start_mark) begin
        t_start          = cyc;
        start_mark       = 1'b0;
        first_valid_seen = 1'b0;
        beats_rcvd       = 0;
        pulses           = 0;
      end
      if (o_rd_en != 4'b0000) begin
        check("rd_en_set", {60'd0, o_rd_en}, frame_sel ? 64'h3 : 64'hC);
        if (pulses == 0) begin
          check("first_rd_cycle", 64'(cyc), 64'(t_start + 1));
          check("first_rd_addr", {55'd0, o_rd_addr}, 64'd0);
        end
        pulses++;
      end
      if (prev_stall) begin
        check("hold_valid", {63'd0, o_valid}, 64'd1);
        check("hold_payload", {21'd0, o_data, o_tag, o_last}, {21'd0, prev_out});
      end
      if (o_valid && !first_valid_seen) begin
        first_valid_seen = 1'b1;
        check("first_valid_cycle", 64'(cyc), 64'(t_start + 3));
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", {32'd0, o_data}, {32'd0, e.d});
          check("beat_tag", {54'd0, o_tag}, {54'd0, e.tag});
          check("beat_last", {63'd0, o_last}, {63'd0, e.last});
        end
        beats_rcvd++;
      end
      if (o_done) begin
        done_cnt++;
        check("done_all_beats", 64'(exp_q.size()), 64'd0);
        check("done_rd_pulses", 64'(pulses), 64'd512);
        check("done_busy_low", {63'd0, o_busy}, 64'd0);
        if (gapless) check("done_cycle", 64'(cyc), 64'(t_start + 1027));
      end
      prev_stall = o_valid && !i_ready;
      prev_out   = {o_data, o_tag, o_last};
    end
  end

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_ready = rmode ? ($urandom_range(99) >= 30) : 1'b1;
    end
  end

  task automatic start_frame(input bit sel);
    @(posedge clk);
    #1;
    salt       = $urandom;
    frame_sel  = sel;
    push_frame(sel);
    start_mark = 1'b1;
    i_sel_mem1 = sel;
    i_start    = 1'b1;
    @(posedge clk);
    #1;
    i_start    = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int  d0;
    bit  seen;
    d0   = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      if (done_cnt != d0) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    repeat (5) @(posedge clk);
  endtask

  task automatic wait_beats(input int n, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      if (beats_rcvd >= n) ok = 1'b1;
    end
    if (!ok) check("beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {21'd0, o_rd_en, o_rd_addr, o_valid, o_tag, o_last, o_busy, o_done},
          64'd0);
    check({name, "_data"}, {32'd0, o_data}, 64'd0);
  endtask

  initial begin
    int d_before;
    i_rst = 1'b1; i_start = 1'b0; i_sel_mem1 = 1'b0;
    rmode = 1'b0; gapless = 1'b0; start_mark = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check_outputs_zero("reset_outputs");
    i_rst = 1'b0;
    repeat (3) @(posedge clk);

    // Frame on mem1, ready always high: gapless with fixed latencies.
    gapless = 1'b1;
    start_frame(1'b1);
    wait_done(2000);
    check("done_count_a", 64'(done_cnt), 64'd1);

    // Frame on mem2, ready always high.
    start_frame(1'b0);
    wait_done(2000);
    check("done_count_b", 64'(done_cnt), 64'd2);

    // Random backpressure, ~30% ready-low.
    gapless = 1'b0;
    rmode   = 1'b1;
    start_frame(1'($urandom_range(1)));
    wait_done(6000);
    check("done_count_c", 64'(done_cnt), 64'd3);

    // Second start mid-frame is ignored (different select to make it visible).
    rmode = 1'b0;
    start_frame(1'b1);
    wait_beats(100, 2000);
    @(posedge clk);
    #1;
    i_sel_mem1 = 1'b0;
    i_start    = 1'b1;
    @(posedge clk);
    #1;
    i_start    = 1'b0;
    wait_done(2000);
    repeat (20) @(posedge clk);
    check("done_count_d", 64'(done_cnt), 64'd4);

    // Asynchronous reset mid-frame, then a fresh frame from beat 0.
    rmode = 1'b1;
    start_frame(1'($urandom_range(1)));
    wait_beats(500, 4000);
    #3;
    i_rst = 1'b1;
    exp_q.delete();
    #1;
    check_outputs_zero("midframe_reset_outputs");
    d_before = done_cnt;
    repeat (3) @(posedge clk);
    #3;
    check_outputs_zero("reset_held_outputs");
    i_rst = 1'b0;
    repeat (3) @(posedge clk);
    check("no_done_after_abort", 64'(done_cnt), 64'(d_before));
    start_frame(1'($urandom_range(1)));
    wait_done(6000);
    check("done_count_f", 64'(done_cnt), 64'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
